key_digit_ctrl: RTL
===================

// Module: key_digit_ctrl
// PURPOSE
// - Control front-end for the digit display path: synchronises and debounces the board keys,
//   turns presses into a working value 0..MAX_VAL, and commits it to the renderer once per frame.
// - The renderer therefore sees a value that only changes at the vsync leading edge, never mid-frame.
// - Sits between the board keys/timing generator and the digit datapath; runs on the pixel-domain clock.
// PARAMETERS
// - DEB_CYCLES    500000  consecutive stable cycles required to accept a key level change (>=2)
// - MAX_VAL       9       highest value; value range 0..MAX_VAL, wraps both ways
// - VAL_W         4       width of value/digit (must hold MAX_VAL)
// - VS_POL        0       vsync active level (0 = active-low, as produced by the timing generator)
// - REPEAT_DELAY  250000  hold cycles before first auto-repeat (AUTOREPEAT_EN only)
// - REPEAT_RATE   100000  cycles between auto-repeats (AUTOREPEAT_EN only)
// PORTS
// - clk         in   1      single clock, all logic rising-edge
// - reset       in   1      asynchronous, active-low reset
// - keys        in   4      raw async keys, active-high: [0] dec, [1] inc, [2] clear, [3] freeze
// - vsync       in   1      vsync from timing generator, polarity per VS_POL
// - digit       out  VAL_W  committed value for renderer, frame-stable
// - pending     out  1      working value differs from committed/unsent change outstanding
// - commit      out  1      1-cycle pulse when digit is updated
// BEHAVIOUR
// - Reset (async assert, sync-free deassert): all sync/debounce regs 0, working value 0, digit 0,
//   pending 0, commit 0, FSM IDLE, repeat counters 0.
// - Sync: 2-flop synchroniser per key and for vsync; 2-cycle input latency.
// - Debounce: per key, counter clears whenever synced level equals debounced level; when it differs
//   for DEB_CYCLES consecutive cycles, debounced level flips, counter clears.
// - Press event: rising edge of debounced level -> 1-cycle internal pulse. Releases produce nothing.
// - Working value (updated cycle after event), priority: clear -> 0; else inc and dec together -> no
//   change; else inc: MAX_VAL wraps to 0; else dec: 0 wraps to MAX_VAL. Clear when already 0 still
//   counts as a change (sets pending).
// - Frame edge: synced vsync transition from inactive to active level (VS_POL), 1-cycle pulse.
// - FSM: IDLE -(any value event)-> PEND; PEND -(frame edge & freeze debounced low)-> COMMIT;
//   COMMIT -> IDLE (1 cycle; digit<=working value, commit=1). If a value event coincides with
//   the COMMIT cycle, next state is PEND.
// - Event and frame edge in same cycle: commit uses the pre-event working value; new event leaves
//   FSM in PEND so it commits on the next frame edge.
// - Freeze held: stays PEND, events keep accumulating; first frame edge after freeze release commits.
// - pending = (state != IDLE). commit high only in COMMIT.
// - Reset mid-debounce or mid-PEND: everything returns to reset values, no commit pulse.
// - Latency: debounced press at cycle N -> working value N+1 -> digit at next frame edge + 1.
// CONFIGURATION
// - AUTOREPEAT_EN defined: while inc or dec debounced high (alone), after REPEAT_DELAY cycles
//   an extra event fires, then every REPEAT_RATE cycles until release; counters reset on release.
// - AUTOREPEAT_EN undefined: one event per press only; REPEAT_* parameters ignored, no repeat logic.
// TESTING (bench uses DEB_CYCLES=4, MAX_VAL=9, REPEAT_DELAY=20, REPEAT_RATE=8)
// - Reset low then release; no keys -> digit=0, pending=0, commit never pulses over 3 frames.
// - keys[1] pulse 3 cycles (glitch) -> no change; keys[1] held 10 cycles -> pending=1, next vsync
//   edge -> commit pulse, digit=1.
// - From 9 press inc -> digit 0 after frame edge; from 0 press dec -> digit 9.
// - keys[0] and keys[1] rise together -> no change, pending stays 0; keys[2] at value 5 -> digit 0.
// - Hold keys[3], press inc twice across 2 frame edges -> digit unchanged, pending=1; release
//   freeze -> next frame edge digit=+2.
// - AUTOREPEAT_EN: hold inc 60 cycles from 0 -> events at press, +20, +28, +36, +44, +52 -> digit 6.

Source files
------------

// File: rtl/key_digit_ctrl.sv
// -----------------------------------------------------------------------------
// key_digit_ctrl
//
// Control front-end for the digit display path. Synchronises and debounces the
// four board keys, turns key presses into a working value 0..MAX_VAL and
// commits that value to the renderer at the vsync leading edge. The renderer
// therefore only ever sees the digit change between frames.
//
// Optional feature (compile-time macro): AUTOREPEAT_EN
//   defined   : holding inc or dec alone fires an extra event after
//               REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
//   undefined : exactly one event per press; REPEAT_* are not used.
//
// Ports
//   clk      in   1      pixel-domain clock, rising edge
//   reset    in   1      asynchronous reset, active low
//   keys     in   4      raw async keys, active high:
//                        [0] dec, [1] inc, [2] clear, [3] freeze
//   vsync    in   1      vsync from the timing generator, active level VS_POL
//   digit    out  VAL_W  committed, frame-stable value for the renderer
//   pending  out  1      a value change is waiting to be committed
//   commit   out  1      one-cycle pulse, high in the cycle digit changes
// -----------------------------------------------------------------------------
module key_digit_ctrl #(
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned MAX_VAL      = 9,
    parameter int unsigned VAL_W        = 4,
    parameter bit          VS_POL       = 1'b0,
    parameter int unsigned REPEAT_DELAY = 250000,
    parameter int unsigned REPEAT_RATE  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       keys,
    input  logic             vsync,
    output logic [VAL_W-1:0] digit,
    output logic             pending,
    output logic             commit
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [VAL_W-1:0] VAL_MAX  = VAL_W'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_COMMIT
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [3:0] keys_s1_q, keys_s2_q;
    logic       vs_s1_q, vs_s2_q, vs_prev_q;

    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample the pre-edge values; blocking here would collapse the chains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys_s1_q <= '0;
            keys_s2_q <= '0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            keys_s1_q <= keys;
            keys_s2_q <= keys_s1_q;
            vs_s1_q   <= vsync;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    // Leading edge of the frame: synced vsync enters its active level.
    logic frame_edge;
    assign frame_edge = (vs_s2_q == VS_POL) && (vs_prev_q != VS_POL);

    // ------------------------------------------------------------ debounce
    logic [3:0]            deb_q;
    logic [3:0][DEB_W-1:0] deb_cnt_q;
    logic [2:0]            deb_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q      <= '0;
            deb_cnt_q  <= '0;
            deb_prev_q <= '0;
        end else begin
            deb_prev_q <= deb_q[2:0];
            for (int i = 0; i < 4; i++) begin
                if (keys_s2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    // DEB_CYCLES-th consecutive differing cycle: accept level.
                    deb_q[i]     <= keys_s2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic [2:0] press;
    assign press = deb_q[2:0] & ~deb_prev_q;

    // ---------------------------------------------------------- autorepeat
    logic rep_inc, rep_dec;

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_first_done_q;
    logic             rep_hold, rep_fire;

    // Only a lone inc or dec repeats; both held together is a no-op chord.
    assign rep_hold = deb_q[0] ^ deb_q[1];
    assign rep_fire = rep_hold &&
                      (rep_first_done_q ? (rep_cnt_q == REP_W'(REPEAT_RATE))
                                        : (rep_cnt_q == REP_W'(REPEAT_DELAY)));

    // rep_cnt_q equals the number of cycles since the press (or last repeat),
    // so a fire reloads 1 for the cycle that follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q        <= '0;
            rep_first_done_q <= 1'b0;
        end else if (!rep_hold) begin
            rep_cnt_q        <= '0;
            rep_first_done_q <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt_q        <= REP_W'(1);
            rep_first_done_q <= 1'b1;
        end else begin
            rep_cnt_q        <= rep_cnt_q + 1'b1;
        end
    end

    assign rep_inc = rep_fire & deb_q[1];
    assign rep_dec = rep_fire & deb_q[0];
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;

    // Repeat timing is not built in this configuration; the empty block only
    // keeps REPEAT_DELAY/REPEAT_RATE referenced.
    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_repeat_unused
    end
`endif

    // ------------------------------------------------------- working value
    logic             inc_ev, dec_ev, clr_ev, val_ev;
    logic [VAL_W-1:0] work_q, work_d;

    assign inc_ev = press[1] | rep_inc;
    assign dec_ev = press[0] | rep_dec;
    assign clr_ev = press[2];
    // A clear always counts as a change, even when the value is already 0.
    assign val_ev = clr_ev | (inc_ev ^ dec_ev);

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        work_d = work_q;
        if (clr_ev) begin
            work_d = '0;
        end else if (inc_ev && !dec_ev) begin
            work_d = (work_q == VAL_MAX) ? '0 : work_q + 1'b1;
        end else if (dec_ev && !inc_ev) begin
            work_d = (work_q == '0) ? VAL_MAX : work_q - 1'b1;
        end
    end

    // ------------------------------------------------------------- commit FSM
    state_t           state_q, state_d;
    logic [VAL_W-1:0] digit_q, digit_d;
    logic             late_q, late_d;   // event arrived on the committing edge

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        late_d  = late_q;
        unique case (state_q)
            ST_IDLE: begin
                if (val_ev) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (frame_edge && !deb_q[3]) begin
                    // Capture before this cycle's event lands in work_q, so a
                    // coinciding event is left for the next frame.
                    state_d = ST_COMMIT;
                    digit_d = work_q;
                    late_d  = val_ev;
                end
            end
            ST_COMMIT: begin
                state_d = (val_ev || late_q) ? ST_PEND : ST_IDLE;
                late_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                late_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            digit_q <= '0;
            late_q  <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            late_q  <= late_d;
            work_q  <= work_d;
        end
    end

    assign digit   = digit_q;
    assign pending = (state_q != ST_IDLE);
    assign commit  = (state_q == ST_COMMIT);

endmodule
